// File: rtl/sync_fifo_wm.sv
// rtl/sync_fifo_wm.sv - single-clock FIFO with watermarks, fill count, sticky errors, registered read port
// Optional word parity and perr output when SYNC_FIFO_PARITY_EN is defined.
module sync_fifo_wm #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
`ifdef SYNC_FIFO_PARITY_EN
  output logic             perr,
`endif
  input  logic             clr_err
);

  localparam int DEPTH = 1 << ASIZE;
`ifdef SYNC_FIFO_PARITY_EN
  localparam int MW = DSIZE + 1;
`else
  localparam int MW = DSIZE;
`endif

  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_LEVEL);
  localparam logic [ASIZE:0] PTR_ONE = (ASIZE+1)'(1);

  logic [MW-1:0]  mem [DEPTH];
  logic [ASIZE:0] wptr, rptr, count_next;
  logic           w_acc, r_acc;
  logic [MW-1:0]  wword;

  // Acceptance looks only at the registered flags, never at same-cycle activity.
  assign w_acc = winc & ~wfull;
  assign r_acc = rinc & ~rempty;
  assign count_next = count + {{ASIZE{1'b0}}, w_acc} - {{ASIZE{1'b0}}, r_acc};

`ifdef SYNC_FIFO_PARITY_EN
  assign wword = {^wdata, wdata};
`else
  assign wword = wdata;
`endif

  always_ff @(posedge clk) begin
    if (rst_n && w_acc) begin
      mem[wptr[ASIZE-1:0]] <= wword;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      walmost_full  <= 1'b0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rvalid        <= 1'b0;
      rdata         <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
`ifdef SYNC_FIFO_PARITY_EN
      perr          <= 1'b0;
`endif
    end else begin
      if (w_acc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (r_acc) begin
        rptr  <= rptr + PTR_ONE;
        rdata <= mem[rptr[ASIZE-1:0]][DSIZE-1:0];
      end
      rvalid        <= r_acc;
      count         <= count_next;
      wfull         <= (count_next == DEPTH_C);
      rempty        <= (count_next == '0);
      walmost_full  <= (count_next >= AF_C);
      ralmost_empty <= (count_next <= AE_C);
      // A new error event beats a simultaneous clear.
      overflow      <= (winc & wfull)  | (overflow  & ~clr_err);
      underflow     <= (rinc & rempty) | (underflow & ~clr_err);
`ifdef SYNC_FIFO_PARITY_EN
      perr          <= r_acc & (^mem[rptr[ASIZE-1:0]]);
`endif
    end
  end

endmodule

// File: tb/tb_sync_fifo_wm.sv
// tb/tb_sync_fifo_wm.sv - self-checking bench for sync_fifo_wm against a queue-based reference model
module tb_sync_fifo_wm;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst_n, winc, rinc, clr_err;
  logic [7:0] wdata, rdata;
  logic       wfull, walmost_full, rvalid, rempty, ralmost_empty, overflow, underflow;
  logic [4:0] count;
`ifdef SYNC_FIFO_PARITY_EN
  logic       perr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_rdata;
  logic       m_rvalid, m_ov, m_un;

  sync_fifo_wm dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .wfull(wfull),
    .walmost_full(walmost_full), .rinc(rinc), .rdata(rdata), .rvalid(rvalid),
    .rempty(rempty), .ralmost_empty(ralmost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
`ifdef SYNC_FIFO_PARITY_EN
    .perr(perr),
`endif
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_flags();
    int n;
    n = q.size();
    return {n == DEPTH, n >= AF, n == 0, n <= AE, m_ov, m_un, m_rvalid, 1'b0};
  endfunction

  // Applies one cycle of stimulus and advances the model by the FIFO's rules.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c, input logic rs);
    bit full, empty;
    winc = w; wdata = d; rinc = r; clr_err = c; rst_n = rs;
    @(posedge clk);
    if (!rs) begin
      q.delete();
      m_rvalid = 1'b0; m_rdata = 8'h00; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      m_rvalid = r && !empty;
      if (m_rvalid) m_rdata = q.pop_front();
      if (w && !full) q.push_back(d);
      m_ov = (w && full)  ? 1'b1 : (c ? 1'b0 : m_ov);
      m_un = (r && empty) ? 1'b1 : (c ? 1'b0 : m_un);
    end
    #1;
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    n_checks++;
    if ({rempty, ralmost_empty, wfull, walmost_full} !== 4'b1100) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 1100", {rempty, ralmost_empty, wfull, walmost_full});
    end
    n_checks++;
    if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++;
    if ({rvalid, rdata, overflow, underflow} !== 11'd0) begin
      n_errors++; $display("FAIL reset_read: got rvalid=%b rdata=%h ov=%b un=%b expected zeros", rvalid, rdata, overflow, underflow);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'(i + 1), 0, 0, 1);
      n_checks++;
      if ({count, walmost_full, wfull} !== {5'(i + 1), (i + 1) >= AF, (i + 1) == DEPTH}) begin
        n_errors++; $display("FAIL fill_%0d: got count=%0d af=%b full=%b expected count=%0d", i, count, walmost_full, wfull, i + 1);
      end
    end
    step(1, 8'hEE, 0, 0, 1);
    n_checks++;
    if ({overflow, count} !== {1'b1, 5'd16}) begin
      n_errors++; $display("FAIL overflow_set: got ov=%b count=%0d expected ov=1 count=16", overflow, count);
    end
    step(0, 8'h00, 0, 1, 1);
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL overflow_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 8'h00, 1, 0, 1);
      n_checks++;
      if ({rvalid, rdata} !== {1'b1, 8'(i + 1)}) begin
        n_errors++; $display("FAIL drain_%0d: got rvalid=%b rdata=%h expected 1 %h", i, rvalid, rdata, 8'(i + 1));
      end
    end
    n_checks++;
    if ({rempty, count} !== {1'b1, 5'd0}) begin
      n_errors++; $display("FAIL drain_empty: got rempty=%b count=%0d expected 1 0", rempty, count);
    end
    step(0, 8'h00, 1, 0, 1);
    n_checks++;
    if ({underflow, rvalid, rdata} !== {1'b1, 1'b0, 8'h10}) begin
      n_errors++; $display("FAIL underflow_set: got un=%b rvalid=%b rdata=%h expected 1 0 10", underflow, rvalid, rdata);
    end
    step(0, 8'h00, 0, 1, 1);
  endtask

  task automatic test_steady_wrap();
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'($urandom), 1, 0, 1);
      n_checks++;
      if ({count, rvalid, rdata} !== {5'd8, 1'b1, m_rdata}) begin
        n_errors++; $display("FAIL steady_%0d: got count=%0d rvalid=%b rdata=%h expected 8 1 %h", i, count, rvalid, rdata, m_rdata);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1, 0, 1);
      n_checks++;
      if (rdata !== m_rdata) begin n_errors++; $display("FAIL wrap_drain_%0d: got %h expected %h", i, rdata, m_rdata); end
    end
  endtask

  task automatic test_full_empty_simul();
    for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0, 0, 1);
    step(1, 8'h5A, 1, 0, 1);
    n_checks++;
    if ({count, overflow, rvalid, rdata} !== {5'd15, 1'b1, 1'b1, m_rdata}) begin
      n_errors++; $display("FAIL full_simul: got count=%0d ov=%b rvalid=%b rdata=%h expected 15 1 1 %h", count, overflow, rvalid, rdata, m_rdata);
    end
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 1, 1);
    step(1, 8'hA5, 1, 0, 1);
    n_checks++;
    if ({count, underflow, rvalid, overflow} !== {5'd1, 1'b1, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL empty_simul: got count=%0d un=%b rvalid=%b ov=%b expected 1 1 0 0", count, underflow, rvalid, overflow);
    end
    step(0, 8'h00, 1, 1, 1);
    n_checks++;
    if ({rdata, underflow} !== {8'hA5, 1'b0}) begin
      n_errors++; $display("FAIL empty_simul_read: got rdata=%h un=%b expected a5 0", rdata, underflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step(1, 8'(8'h30 + i), 0, 0, 1);
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    n_checks++;
    if ({count, rempty, rvalid, rdata} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
      n_errors++; $display("FAIL reset_mid: got count=%0d rempty=%b rvalid=%b rdata=%h expected 0 1 0 00", count, rempty, rvalid, rdata);
    end
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1, 0, 1);
      n_checks++;
      if ({rvalid, rdata} !== {1'b1, 8'(8'hC0 + i)}) begin
        n_errors++; $display("FAIL reset_new_%0d: got rvalid=%b rdata=%h expected 1 %h", i, rvalid, rdata, 8'(8'hC0 + i));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] got;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 8), 1'b1);
      got = {wfull, walmost_full, rempty, ralmost_empty, overflow, underflow, rvalid, 1'b0};
      n_checks++;
      if ({count, got, rdata} !== {5'(q.size()), exp_flags(), m_rdata}) begin
        n_errors++; $display("FAIL random_%0d: got count=%0d flags=%b rdata=%h expected count=%0d flags=%b rdata=%h",
                             i, count, got, rdata, q.size(), exp_flags(), m_rdata);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    m_rdata = 8'h00; m_rvalid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_steady_wrap();
    test_full_empty_simul();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_wm.md
Name: sync_fifo_wm

Overview:
Single-clock, parametrised successor to the behavioural FIFO (beh_fifo) for same-clock producer/consumer paths.
- Adds programmable almost-full and almost-empty watermarks, a fill-level count, sticky overflow/underflow error flags and a registered read port with a valid strobe.
- Sits between a DSIZE-wide write agent and read agent in one clock domain.
- Keeps the winc/wfull/rinc/rempty handshake naming of the existing FIFO interfaces.

Parameters:
- DSIZE, 8, data word width in bits.
- ASIZE, 4, address width; DEPTH = 2**ASIZE words.
- AF_LEVEL, 14, walmost_full asserts when count >= AF_LEVEL. Legal range: AE_LEVEL < AF_LEVEL <= DEPTH.
- AE_LEVEL, 2, ralmost_empty asserts when count <= AE_LEVEL. Legal range: 0 <= AE_LEVEL < AF_LEVEL.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- winc  input  1  write request.
- wdata  input  DSIZE  write data.
- wfull  output  1  FIFO holds DEPTH words.
- walmost_full  output  1  count >= AF_LEVEL.
- rinc  input  1  read request.
- rdata  output  DSIZE  registered read data.
- rvalid  output  1  rdata updated by a read accepted on the previous edge.
- rempty  output  1  FIFO holds 0 words.
- ralmost_empty  output  1  count <= AE_LEVEL.
- count  output  ASIZE+1  current fill level, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.
- clr_err  input  1  clears overflow and underflow.

Behaviour:
- Reset values, at rising edge with rst_n=0: wptr=0, rptr=0, count=0, rempty=1, ralmost_empty=1, wfull=0, walmost_full=0 (AF_LEVEL>0), rvalid=0, rdata=0, overflow=0, underflow=0. Memory contents are not cleared.
- Pointers: ASIZE+1-bit binary. The low ASIZE bits address memory; the MSB is the wrap bit. Increment modulo 2**(ASIZE+1).
- Write accepted iff winc && !wfull. On accept: mem[wptr] <= wdata; wptr++.
- Read accepted iff rinc && !rempty. On accept: rdata <= mem[rptr]; rptr++.
- Read latency: rvalid=1 for exactly the one cycle after an accepted read. rdata holds its value otherwise.
- Acceptance uses the current registered flags only. A write while wfull is rejected even if a read is accepted in the same cycle, and symmetrically for reads while rempty.
- count_next = count + w_acc - r_acc. Simultaneous accepted read and write leave count unchanged; the read returns the oldest word, never the word written that cycle.
- All flags are registered from count_next, so they are valid the same cycle count changes:
  - wfull = (count_next == DEPTH)
  - rempty = (count_next == 0)
  - walmost_full = (count_next >= AF_LEVEL)
  - ralmost_empty = (count_next <= AE_LEVEL)
- Error flags:
  - overflow sets on winc && wfull; underflow sets on rinc && rempty.
  - Both are cleared only by clr_err or reset.
  - If clr_err and a new error event occur in the same cycle, the set wins.
- Rejected operations do not change pointers, count, memory or rdata.
- Wrap-around: after 2*DEPTH writes and reads, data order is preserved and the full/empty distinction is still correct.
- Reset asserted mid-operation returns every output to its reset value on that edge. A read accepted in the preceding cycle produces no rvalid after reset.

Optional Feature:
- Macro: SYNC_FIFO_PARITY_EN.
- Defined:
  - Each memory word stores DSIZE+1 bits, including an even-parity bit computed on write.
  - On an accepted read, parity is rechecked. Extra output perr (1 bit) is high in the same cycle as rvalid if the stored parity mismatches, else 0. perr resets to 0.
- Undefined: memory is DSIZE wide, no perr port, no parity logic.

Test Plan:
- Reset then idle -> rempty=1, ralmost_empty=1, count=0, wfull=0, rvalid=0, rdata=0.
- Write 0x01..0x10 (16 words, ASIZE=4) -> count=16, wfull=1, walmost_full=1 from count=14. A 17th winc -> overflow=1, count stays 16. clr_err -> overflow=0.
- Read 16 words -> rdata 0x01..0x10 in order, each one cycle after rinc with rvalid=1. rempty=1 at count=0. Extra rinc -> underflow=1, rvalid=0.
- Count at 8 with winc=rinc=1 for 20 cycles -> count stays 8, data order preserved across pointer wrap.
- Full FIFO with winc=rinc=1 -> read accepted, write rejected, overflow=1, count=15. Empty FIFO with winc=rinc=1 -> write accepted, read rejected, underflow=1, count=1.
- rst_n=0 for one cycle while count=5 and rinc=1 -> next cycle count=0, rempty=1, rvalid=0. Subsequent writes and reads return new data only.
